// File: rtl/lut_layer_sched_if.sv
// ---------------------------------------------------------------------------
// lut_layer_sched_if
// Bundles the signals of one time-multiplexed LUT layer sequencer.
//   Input handshake : in_valid, in_ready, in_data
//   Gather network  : sel_data, sel_neuron (to network), sel_bits (back)
//   Truth-table bus : lut_en, lut_addr (to memory), lut_q (back)
//   Output handshake: out_valid, out_ready, out_data
//   Status          : busy
// The master modport is the sequencer. The slave modport is its surroundings.
// ---------------------------------------------------------------------------
interface lut_layer_sched_if #(
   parameter int IN_WIDTH    = 64,
   parameter int NUM_NEURONS = 10,
   parameter int FAN_IN      = 8,
   parameter int NIDX_W      = $clog2(NUM_NEURONS)
);
   logic                     in_valid;
   logic                     in_ready;
   logic [IN_WIDTH-1:0]      in_data;
   logic [IN_WIDTH-1:0]      sel_data;
   logic [NIDX_W-1:0]        sel_neuron;
   logic [FAN_IN-1:0]        sel_bits;
   logic                     lut_en;
   logic [NIDX_W+FAN_IN-1:0] lut_addr;
   logic                     lut_q;
   logic                     out_valid;
   logic                     out_ready;
   logic [NUM_NEURONS-1:0]   out_data;
   logic                     busy;

   modport master (
      input  in_valid, in_data, sel_bits, lut_q, out_ready,
      output in_ready, sel_data, sel_neuron, lut_en, lut_addr, out_valid, out_data, busy
   );

   modport slave (
      output in_valid, in_data, sel_bits, lut_q, out_ready,
      input  in_ready, sel_data, sel_neuron, lut_en, lut_addr, out_valid, out_data, busy
   );
endinterface

// File: rtl/lut_layer_sched.sv
// ---------------------------------------------------------------------------
// lut_layer_sched
// Time-multiplexed sequencer for one LogicNets neuron layer. The block
// captures one activation vector. It issues one shared truth-table lookup per
// neuron, one per cycle, and gathers the 1-bit results into out_data.
//   clk, rst : clock and synchronous active-high reset
//   bus      : lut_layer_sched_if.master (handshakes, gather network,
//              truth-table bus, busy)
// Optional macro LUT_SCHED_PERF_EN adds two saturating 32-bit counters:
//   perf_vec_cnt   : completed output handshakes
//   perf_stall_cnt : cycles in HOLD with out_ready low
// ---------------------------------------------------------------------------
module lut_layer_sched #(
   parameter int IN_WIDTH    = 64,
   parameter int NUM_NEURONS = 10,
   parameter int FAN_IN      = 8,
   parameter int RD_LAT      = 1,
   parameter int NIDX_W      = $clog2(NUM_NEURONS)
) (
   input  logic                      clk,
   input  logic                      rst,
   lut_layer_sched_if.master         bus
`ifdef LUT_SCHED_PERF_EN
   ,
   output logic [31:0]               perf_vec_cnt,
   output logic [31:0]               perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   localparam logic [NIDX_W-1:0] LAST_IDX = NIDX_W'(NUM_NEURONS - 1);

   state_e                 state_q;
   logic                   in_ready_q;
   logic                   lut_en_q;
   logic                   out_valid_q;
   logic                   busy_q;
   logic [IN_WIDTH-1:0]    sel_data_q;
   logic [NIDX_W-1:0]      sel_neuron_q;
   logic [NUM_NEURONS-1:0] out_data_q;

   // Tag pipeline: entry 0 is loaded on the issue edge. Entry RD_LAT-1 lines
   // up with the cycle in which lut_q carries that lookup's result.
   logic                   tag_vld_q [RD_LAT];
   logic [NIDX_W-1:0]      tag_idx_q [RD_LAT];

   logic                   retire_s;
   logic                   last_retire_s;
   logic [FAN_IN-1:0]      sel_bits_s;

   assign retire_s      = tag_vld_q[RD_LAT-1];
   assign last_retire_s = retire_s && (tag_idx_q[RD_LAT-1] == LAST_IDX);
   assign sel_bits_s    = bus.sel_bits;

   // Control FSM plus all registered outputs and the result vector.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         in_ready_q   <= 1'b1;
         lut_en_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         sel_data_q   <= '0;
         sel_neuron_q <= '0;
         out_data_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  sel_data_q   <= bus.in_data;
                  sel_neuron_q <= '0;
                  out_data_q   <= '0;
                  in_ready_q   <= 1'b0;
                  lut_en_q     <= 1'b1;
                  busy_q       <= 1'b1;
                  state_q      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (sel_neuron_q == LAST_IDX) begin
                  sel_neuron_q <= '0;
                  lut_en_q     <= 1'b0;
                  state_q      <= ST_DRAIN;
               end else begin
                  sel_neuron_q <= sel_neuron_q + NIDX_W'(1);
               end
            end
            ST_DRAIN: begin
               // Tags retire in issue order, so the last neuron's tag is the final one.
               if (last_retire_s) begin
                  out_valid_q <= 1'b1;
                  state_q     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               in_ready_q  <= 1'b1;
               lut_en_q    <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
         // A retiring tag is never present in IDLE, so this never races the clear.
         if (retire_s) begin
            out_data_q[tag_idx_q[RD_LAT-1]] <= bus.lut_q;
         end
      end
   end

   // Tag pipeline shift: {valid, neuron index} follows each lookup to its result.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            tag_vld_q[i] <= 1'b0;
            tag_idx_q[i] <= '0;
         end
      end else begin
         tag_vld_q[0] <= lut_en_q;
         tag_idx_q[0] <= sel_neuron_q;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_idx_q[i] <= tag_idx_q[i-1];
         end
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.sel_data   = sel_data_q;
   assign bus.sel_neuron = sel_neuron_q;
   assign bus.lut_en     = lut_en_q;
   assign bus.lut_addr   = {sel_neuron_q, sel_bits_s};
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.busy       = busy_q;

`ifdef LUT_SCHED_PERF_EN
   logic [31:0] perf_vec_q;
   logic [31:0] perf_stall_q;

   // Saturating counters for completed vectors and output backpressure cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_vec_q   <= 32'd0;
         perf_stall_q <= 32'd0;
      end else begin
         if (out_valid_q && bus.out_ready && (perf_vec_q != 32'hFFFF_FFFF)) begin
            perf_vec_q <= perf_vec_q + 32'd1;
         end
         if ((state_q == ST_HOLD) && !bus.out_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_vec_cnt   = perf_vec_q;
   assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_lut_layer_sched.sv
// ---------------------------------------------------------------------------
// tb_lut_layer_sched
// Self-checking bench for lut_layer_sched. Instance A uses RD_LAT=1 and
// instance B uses RD_LAT=3. Each instance has a gather network and a
// truth-table memory model. Expected layer outputs come from a direct
// per-neuron evaluation of the selected truth table.
// ---------------------------------------------------------------------------
module tb_lut_layer_sched;
   localparam int IW  = 64;
   localparam int NN  = 10;
   localparam int FI  = 8;
   localparam int NW  = 4;
   localparam int RDA = 1;
   localparam int RDB = 3;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;
   int   tt_mode = 0;
   logic tt_rand [0:NN*(1<<FI)-1];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lut_layer_sched_if #(.IN_WIDTH(IW), .NUM_NEURONS(NN), .FAN_IN(FI), .NIDX_W(NW)) ifa ();
   lut_layer_sched_if #(.IN_WIDTH(IW), .NUM_NEURONS(NN), .FAN_IN(FI), .NIDX_W(NW)) ifb ();

`ifdef LUT_SCHED_PERF_EN
   logic [31:0] pv_a, ps_a, pv_b, ps_b;
`endif

   lut_layer_sched #(.IN_WIDTH(IW), .NUM_NEURONS(NN), .FAN_IN(FI), .RD_LAT(RDA)) u_dut_a (
      .clk(clk), .rst(rst), .bus(ifa.master)
`ifdef LUT_SCHED_PERF_EN
      , .perf_vec_cnt(pv_a), .perf_stall_cnt(ps_a)
`endif
   );

   lut_layer_sched #(.IN_WIDTH(IW), .NUM_NEURONS(NN), .FAN_IN(FI), .RD_LAT(RDB)) u_dut_b (
      .clk(clk), .rst(rst), .bus(ifb.master)
`ifdef LUT_SCHED_PERF_EN
      , .perf_vec_cnt(pv_b), .perf_stall_cnt(ps_b)
`endif
   );

   // Gather network: neuron k reads bits (7k + 5j) mod IW of the vector.
   function automatic logic [FI-1:0] gather(input logic [IW-1:0] v, input int k);
      logic [FI-1:0] b;
      for (int j = 0; j < FI; j++) b[j] = v[(k*7 + j*5) % IW];
      return b;
   endfunction

   function automatic logic tt_val(input int k, input logic [FI-1:0] b);
      case (tt_mode)
         0:       return (k % 2) == 1;
         1:       return ^b;
         2:       return tt_rand[k*(1<<FI) + int'(b)];
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [NN-1:0] model(input logic [IW-1:0] v);
      logic [NN-1:0] r;
      for (int k = 0; k < NN; k++) r[k] = tt_val(k, gather(v, k));
      return r;
   endfunction

   always_comb ifa.sel_bits = gather(ifa.sel_data, int'(ifa.sel_neuron));
   always_comb ifb.sel_bits = gather(ifb.sel_data, int'(ifb.sel_neuron));

   // Truth-table memories: the result appears RD_LAT cycles after lut_en.
   // When the strobe is low, the memory output is random.
   logic       pipe_a;
   logic [2:0] pipe_b;
   always @(posedge clk) begin
      pipe_a <= ifa.lut_en ? tt_val(int'(ifa.lut_addr[NW+FI-1:FI]), ifa.lut_addr[FI-1:0]) : 1'($urandom);
      pipe_b <= {pipe_b[1:0], ifb.lut_en ? tt_val(int'(ifb.lut_addr[NW+FI-1:FI]), ifb.lut_addr[FI-1:0]) : 1'($urandom)};
   end
   assign ifa.lut_q = pipe_a;
   assign ifb.lut_q = pipe_b[2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [IW-1:0] rvec();
      return {$urandom, $urandom};
   endfunction

   // One vector through instance A, with hold cycles of output backpressure.
   // During the hold, in_valid is asserted with nxt.
   task automatic run_a(input logic [IW-1:0] vec, input int hold, input logic [IW-1:0] nxt,
                        output logic [NN-1:0] got);
      logic [NN-1:0] exp;
      int c;
      exp = model(vec);
      chk("a_idle_in_ready", ifa.in_ready, 1);
      ifa.in_valid = 1'b1; ifa.in_data = vec; ifa.out_ready = 1'b0;
      @(negedge clk); c = 1;
      ifa.in_valid = 1'b0; ifa.in_data = ~vec;
      while (!ifa.out_valid && c < 40) begin
         chk("a_lut_en", ifa.lut_en, (c <= NN));
         if (c <= NN) begin
            chk("a_issue_idx", ifa.lut_addr[NW+FI-1:FI], c - 1);
            chk("a_issue_bits", ifa.lut_addr[FI-1:0], gather(vec, c - 1));
         end
         chk("a_sel_data", ifa.sel_data, vec);
         chk("a_ready_busy", {ifa.in_ready, ifa.busy}, 2'b01);
         @(negedge clk); c++;
      end
      chk("a_out_valid_cycle", c, NN + RDA + 1);
      chk("a_out_data", ifa.out_data, exp);
      got = ifa.out_data;
      ifa.in_valid = (hold > 0); ifa.in_data = nxt;
      for (int h = 0; h < hold; h++) begin
         chk("a_hold_valid", ifa.out_valid, 1);
         chk("a_hold_data", ifa.out_data, exp);
         chk("a_hold_in_ready", ifa.in_ready, 0);
         chk("a_hold_sel_data", ifa.sel_data, vec);
         @(negedge clk);
      end
      ifa.out_ready = 1'b1;
      @(negedge clk);
      ifa.out_ready = 1'b0;
      chk("a_post_valid", ifa.out_valid, 0);
      chk("a_post_in_ready", ifa.in_ready, 1);
   endtask

   initial begin
      logic [NN-1:0] got;
      logic [IW-1:0] v1, v2, vb;
      logic [IW-1:0] vecs [5];
      logic [NN-1:0] exq [$];
      logic [NN-1:0] ev;
      int c, acc_n, out_n, last_acc, guard;

      for (int i = 0; i < NN*(1<<FI); i++) tt_rand[i] = 1'($urandom);
      rst = 1'b1;
      ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
      ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_in_ready", ifa.in_ready, 1);
      chk("rst_out_valid", ifa.out_valid, 0);
      chk("rst_lut_en", ifa.lut_en, 0);
      chk("rst_out_data", ifa.out_data, 0);
      chk("rst_busy", ifa.busy, 0);
      chk("rst_sel", {ifa.sel_neuron, ifa.sel_data}, 0);
      rst = 1'b0;
      @(negedge clk);

      // Odd-neuron truth table
      tt_mode = 0;
      run_a(rvec(), 0, '0, got);
      v1 = IW'(10'b1010101010);
      chk("odd_pattern", got, v1);

      // RD_LAT=3 with XOR-reduce table on the fixed vector
      tt_mode = 1;
      vb = 64'hA5A5_0F0F_3C3C_FF00;
      ifb.in_valid = 1'b1; ifb.in_data = vb;
      @(negedge clk); c = 1;
      ifb.in_valid = 1'b0;
      while (!ifb.out_valid && c < 40) begin
         @(negedge clk); c++;
      end
      chk("b_out_valid_cycle", c, NN + RDB + 1);
      chk("b_out_data", ifb.out_data, model(vb));
      ifb.out_ready = 1'b1;
      @(negedge clk);
      ifb.out_ready = 1'b0;
      chk("b_post_valid", ifb.out_valid, 0);

      // Backpressure: 20 stalled cycles with in_valid asserted, then the next vector
      tt_mode = 2;
      v1 = rvec(); v2 = rvec();
      run_a(v1, 20, v2, got);
      run_a(v2, 0, '0, got);
`ifdef LUT_SCHED_PERF_EN
      chk("perf_stall_20", ps_a, 20);
      chk("perf_vec_3", pv_a, 3);
`endif

      // Reset in cycle 5 of ISSUE using an all-ones table, so any late write shows up
      tt_mode = 3;
      chk("r_idle", ifa.in_ready, 1);
      ifa.in_valid = 1'b1; ifa.in_data = rvec();
      @(negedge clk);
      ifa.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("r_pre_busy", ifa.busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("r_in_ready", ifa.in_ready, 1);
      chk("r_busy", ifa.busy, 0);
      chk("r_lut_en", ifa.lut_en, 0);
      chk("r_out_valid", ifa.out_valid, 0);
      chk("r_out_data", ifa.out_data, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("r_late_data", ifa.out_data, 0);
         chk("r_late_busy", ifa.busy, 0);
      end
      run_a(rvec(), 0, '0, got);

      // Random truth tables and random vectors
      tt_mode = 2;
      for (int i = 0; i < 3; i++) run_a(rvec(), i, rvec(), got);

      // Back-to-back vectors with in_valid and out_ready held high
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) vecs[i] = rvec();
      acc_n = 0; out_n = 0; last_acc = -1; guard = 0;
      ifa.in_valid = 1'b1; ifa.out_ready = 1'b1; ifa.in_data = vecs[0];
      while (out_n < 5 && guard < 200) begin
         if (ifa.out_valid) begin
            ev = (exq.size() > 0) ? exq.pop_front() : 'x;
            chk("b2b_data", ifa.out_data, ev);
            out_n++;
         end
         if (ifa.in_valid && ifa.in_ready) begin
            if (last_acc >= 0) chk("b2b_spacing", cyc - last_acc, NN + RDA + 2);
            last_acc = cyc;
            exq.push_back(model(ifa.in_data));
            acc_n++;
         end else if (!ifa.in_ready) begin
            ifa.in_valid = (acc_n < 5);
            if (acc_n < 5) ifa.in_data = vecs[acc_n];
         end
         @(negedge clk);
         guard++;
      end
      chk("b2b_count", out_n, 5);
      ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
`ifdef LUT_SCHED_PERF_EN
      chk("perf_vec_5", pv_a, 5);
      chk("perf_stall_0", ps_a, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
